// File: rtl/intersection_model.sv
// -----------------------------------------------------------------------------
// intersection_model
//
// Purpose:
//   Cycle-level model of two traffic queues (NS = "a", EW = "b") at a
//   signalised intersection. Each direction owns an identical, independent
//   controller (STOP / START / FLOW plus a 4-bit timer) that turns a sampled
//   green light into a paced train of one-car departure slots, and a
//   saturating queue counter fed by one-car-per-edge arrivals.
//
// Parameters:
//   QMAX       maximum queue depth per direction (1..15)
//   START_DLY  edges from the first green sample to the first departure slot
//   DEP_GAP    edges between successive departure slots
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   Reset      synchronous, active-high reset
//   La, Lb     NS / EW light: 0 green, 1 yellow, 2 red, 3 illegal
//   arr_a/b    car arrival, one car per sampled-high edge
//   Ta, Tb     traffic present, decoded from the registered queue depth
//   cnt_a/b    registered queue depth
//   dep_a/b    registered one-cycle pulse per departed car
//   ovf        sticky: an arrival was dropped on a full queue
//   conflict   sticky: both lights were non-red on the same edge
//   illegal    sticky: a light was sampled as code 3
//
// Configuration:
//   INTERSECTION_SAFETY_CHECK_EN  when defined, builds the conflict/illegal
//                                 detectors; otherwise both flags are tied 0.
// -----------------------------------------------------------------------------
module intersection_model #(
    parameter int unsigned QMAX      = 15,
    parameter int unsigned START_DLY = 2,
    parameter int unsigned DEP_GAP   = 2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    input  logic       arr_a,
    input  logic       arr_b,
    output logic       Ta,
    output logic       Tb,
    output logic [3:0] cnt_a,
    output logic [3:0] cnt_b,
    output logic       dep_a,
    output logic       dep_b,
    output logic       ovf,
    output logic       conflict,
    output logic       illegal
);

    localparam logic [1:0] LightGreen   = 2'd0;
    localparam logic [1:0] LightRed     = 2'd2;
    localparam logic [1:0] LightIllegal = 2'd3;

    localparam logic [3:0] QMaxCnt   = 4'(QMAX);
    localparam logic [3:0] StartLoad = 4'(START_DLY);
    // The slot edge itself counts as one of the DEP_GAP edges.
    localparam logic [3:0] GapLoad   = 4'(DEP_GAP - 1);

    typedef enum logic [1:0] {
        StStop  = 2'd0,
        StStart = 2'd1,
        StFlow  = 2'd2
    } ctrl_state_e;

    // Index 0 = NS (a), index 1 = EW (b).
    ctrl_state_e state_q [2];
    ctrl_state_e state_d [2];
    logic [3:0]  timer_q [2];
    logic [3:0]  timer_d [2];
    logic [3:0]  cnt_q   [2];
    logic [3:0]  cnt_d   [2];
    logic [1:0]  dep_q;
    logic [1:0]  dep_d;
    logic        ovf_q;
    logic        ovf_d;

    logic [1:0]  light [2];
    logic [1:0]  arr;
    logic [1:0]  slot;
    logic [1:0]  ovf_set;

    assign light[0] = La;
    assign light[1] = Lb;
    assign arr      = {arr_b, arr_a};

    // -------------------------------------------------------------------------
    // Per-direction controller and queue counter
    // -------------------------------------------------------------------------
    always_comb begin
        ovf_set = 2'b00;
        slot    = 2'b00;
        dep_d   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            cnt_d[i]   = cnt_q[i];

            // Yellow, red and code 3 all count as "not green".
            unique case (state_q[i])
                StStop: begin
                    if (light[i] == LightGreen) begin
                        state_d[i] = StStart;
                        timer_d[i] = StartLoad;
                    end
                end
                StStart: begin
                    if (light[i] != LightGreen) begin
                        state_d[i] = StStop;
                        timer_d[i] = 4'd0;
                    end else if (timer_q[i] <= 4'd1) begin
                        state_d[i] = StFlow;
                        slot[i]    = 1'b1;
                    end else begin
                        timer_d[i] = timer_q[i] - 4'd1;
                    end
                end
                StFlow: begin
                    if (light[i] != LightGreen) begin
                        state_d[i] = StStop;
                        timer_d[i] = 4'd0;
                    end else if (timer_q[i] != 4'd0) begin
                        timer_d[i] = timer_q[i] - 4'd1;
                    end else begin
                        slot[i] = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = StStop;
                    timer_d[i] = 4'd0;
                end
            endcase

            // A slot only departs a car already queued before this edge, so a
            // same-edge arrival into an empty queue cannot leave immediately.
            if (slot[i]) begin
                if (cnt_q[i] != 4'd0) begin
                    dep_d[i]   = 1'b1;
                    timer_d[i] = GapLoad;
                end else begin
                    timer_d[i] = 4'd0;
                end
            end

            // Arrival+departure cancel, which also lets a full queue accept
            // a car on a departure edge without overflowing.
            unique case ({arr[i], dep_d[i]})
                2'b10: begin
                    if (cnt_q[i] >= QMaxCnt) begin
                        ovf_set[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end
                2'b01: begin
                    cnt_d[i] = cnt_q[i] - 4'd1;
                end
                default: begin
                    cnt_d[i] = cnt_q[i];
                end
            endcase
        end
        ovf_d = ovf_q | (|ovf_set);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StStop;
                timer_q[i] <= 4'd0;
                cnt_q[i]   <= 4'd0;
            end
            dep_q <= 2'b00;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            dep_q <= dep_d;
            ovf_q <= ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional safety monitors
    // -------------------------------------------------------------------------
`ifdef INTERSECTION_SAFETY_CHECK_EN
    logic conflict_q;
    logic conflict_d;
    logic illegal_q;
    logic illegal_d;

    always_comb begin
        conflict_d = conflict_q | ((La != LightRed) && (Lb != LightRed));
        illegal_d  = illegal_q | (La == LightIllegal) | (Lb == LightIllegal);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            conflict_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
            illegal_q  <= illegal_d;
        end
    end

    assign conflict = conflict_q;
    assign illegal  = illegal_q;
`else
    assign conflict = 1'b0;
    assign illegal  = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs: everything comes straight from flops
    // -------------------------------------------------------------------------
    assign cnt_a = cnt_q[0];
    assign cnt_b = cnt_q[1];
    assign Ta    = (cnt_q[0] != 4'd0);
    assign Tb    = (cnt_q[1] != 4'd0);
    assign dep_a = dep_q[0];
    assign dep_b = dep_q[1];
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_intersection_model.sv
// -----------------------------------------------------------------------------
// tb_intersection_model
//
// Directed, self-checking bench for intersection_model with default
// parameters (QMAX=15, START_DLY=2, DEP_GAP=2). Inputs change and outputs are
// sampled 1 time unit after each rising edge. Expected flag values follow
// INTERSECTION_SAFETY_CHECK_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_intersection_model;

`ifdef INTERSECTION_SAFETY_CHECK_EN
    localparam logic SafetyEn = 1'b1;
`else
    localparam logic SafetyEn = 1'b0;
`endif

    logic       clk;
    logic       Reset;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       arr_a;
    logic       arr_b;
    logic       Ta;
    logic       Tb;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
    logic       dep_a;
    logic       dep_b;
    logic       ovf;
    logic       conflict;
    logic       illegal;

    int unsigned n_total;
    int unsigned n_pass;

    intersection_model dut (
        .clk      (clk),
        .Reset    (Reset),
        .La       (La),
        .Lb       (Lb),
        .arr_a    (arr_a),
        .arr_b    (arr_b),
        .Ta       (Ta),
        .Tb       (Tb),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .dep_a    (dep_a),
        .dep_b    (dep_b),
        .ovf      (ovf),
        .conflict (conflict),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        Reset   = 1'b1;
        La      = 2'd2;
        Lb      = 2'd2;
        arr_a   = 1'b0;
        arr_b   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        check("rst_cnt_b", 32'(cnt_b), 32'd0);
        check("rst_Ta", 32'(Ta), 32'd0);
        check("rst_Tb", 32'(Tb), 32'd0);
        check("rst_dep_a", 32'(dep_a), 32'd0);
        check("rst_dep_b", 32'(dep_b), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_conflict", 32'(conflict), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // Three NS arrivals on red
        Reset = 1'b0;
        La    = 2'd2;
        Lb    = 2'd0;
        arr_a = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("fill3_cnt_a", 32'(cnt_a), 32'(k));
            check("fill3_dep_a", 32'(dep_a), 32'd0);
        end
        arr_a = 1'b0;
        check("fill3_Ta", 32'(Ta), 32'd1);

        // Green at e0 (j=0): departures after e0+2, e0+4, e0+6
        La = 2'd0;
        Lb = 2'd2;
        for (int j = 0; j < 8; j++) begin
            tick();
            check("drain_dep_a", 32'(dep_a), 32'((j == 2) || (j == 4) || (j == 6)));
            check("drain_cnt_a", 32'(cnt_a),
                  32'(3 - int'(j >= 2) - int'(j >= 4) - int'(j >= 6)));
        end
        check("drain_Ta", 32'(Ta), 32'd0);

        // Arrival into empty queue while waiting in FLOW cannot depart same edge
        arr_a = 1'b1;
        tick();
        check("empty_arr_dep_a", 32'(dep_a), 32'd0);
        check("empty_arr_cnt_a", 32'(cnt_a), 32'd1);
        arr_a = 1'b0;
        tick();
        check("empty_next_dep_a", 32'(dep_a), 32'd1);
        check("empty_next_cnt_a", 32'(cnt_a), 32'd0);

        // Saturation: 17 arrivals on red, queue starts empty
        La    = 2'd2;
        arr_a = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            tick();
            check("sat_cnt_a", 32'(cnt_a), 32'((j > 15) ? 15 : j));
            check("sat_ovf", 32'(ovf), 32'(j >= 16));
        end
        arr_a = 1'b0;
        Reset = 1'b1;
        tick();
        check("sat_rst_cnt_a", 32'(cnt_a), 32'd0);
        check("sat_rst_ovf", 32'(ovf), 32'd0);
        check("sat_rst_Ta", 32'(Ta), 32'd0);
        Reset = 1'b0;

        // Full queue departing with simultaneous arrival
        Lb    = 2'd2;
        arr_a = 1'b1;
        for (int j = 0; j < 15; j++) tick();
        check("full_cnt_a", 32'(cnt_a), 32'd15);
        arr_a = 1'b0;
        La    = 2'd0;
        tick();
        tick();
        arr_a = 1'b1;
        tick();
        check("full_dep_a", 32'(dep_a), 32'd1);
        check("full_cnt_a_hold", 32'(cnt_a), 32'd15);
        check("full_ovf", 32'(ovf), 32'd0);
        arr_a = 1'b0;
        tick();
        check("full_gap_dep_a", 32'(dep_a), 32'd0);
        check("full_gap_cnt_a", 32'(cnt_a), 32'd15);

        // EW: yellow interrupts FLOW, then green restarts after START_DLY
        La    = 2'd2;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        arr_b = 1'b1;
        for (int j = 0; j < 6; j++) tick();
        arr_b = 1'b0;
        check("ew_fill_cnt_b", 32'(cnt_b), 32'd6);
        Lb = 2'd0;
        tick();
        tick();
        tick();
        check("ew_first_dep_b", 32'(dep_b), 32'd1);
        check("ew_first_cnt_b", 32'(cnt_b), 32'd5);
        Lb = 2'd1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("ew_yellow_dep_b", 32'(dep_b), 32'd0);
            check("ew_yellow_cnt_b", 32'(cnt_b), 32'd5);
        end
        Lb = 2'd0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("ew_restart_dep_b", 32'(dep_b), 32'(j == 2));
            check("ew_restart_cnt_b", 32'(cnt_b), 32'((j == 2) ? 4 : 5));
        end

        // Safety flags and code 3 treated as red
        Lb    = 2'd2;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        arr_a = 1'b1;
        tick();
        tick();
        arr_a = 1'b0;
        check("safe_cnt_a", 32'(cnt_a), 32'd2);
        check("safe_conflict_pre", 32'(conflict), 32'd0);
        La = 2'd0;
        Lb = 2'd1;
        tick();
        check("safe_conflict", 32'(conflict), 32'(SafetyEn));
        La = 2'd3;
        Lb = 2'd2;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("safe_code3_dep_a", 32'(dep_a), 32'd0);
            check("safe_code3_cnt_a", 32'(cnt_a), 32'd2);
        end
        check("safe_illegal", 32'(illegal), 32'(SafetyEn));
        check("safe_conflict_sticky", 32'(conflict), 32'(SafetyEn));

        // Reset on the departure-slot edge suppresses the pulse
        La = 2'd0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        check("midrst_dep_a", 32'(dep_a), 32'd0);
        check("midrst_cnt_a", 32'(cnt_a), 32'd0);
        check("midrst_illegal", 32'(illegal), 32'd0);
        check("midrst_conflict", 32'(conflict), 32'd0);

        // First edge after reset: STOP with empty queue
        Reset = 1'b0;
        La    = 2'd2;
        arr_a = 1'b1;
        tick();
        arr_a = 1'b0;
        check("post_rst_cnt_a", 32'(cnt_a), 32'd1);
        check("post_rst_dep_a", 32'(dep_a), 32'd0);
        tick();
        check("post_rst_Ta", 32'(Ta), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
